// File: rtl/usb_annunciator_sched.sv
// Byte sequencer for the annunciator UART: pulls periodic status frames from the annunciator
// and fills the idle time between frames with bytes from the log stream.
module usb_annunciator_sched #(
    parameter int unsigned FRAME_LEN   = 497,
    parameter int unsigned REFRESH_DIV = 4800000,
    parameter int unsigned ANN_LAT     = 3
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       enable,
    output logic       ann_inc,
    input  logic [7:0] ann_dout,
    input  logic       ann_dout_v,
    input  logic [7:0] log_data,
    input  logic       log_valid,
    output logic       log_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       frame_active,
    output logic       frame_overrun
);

    typedef enum logic [1:0] {StIdle, StAnnReq, StTxWait, StAnnGap} state_e;

    localparam logic [22:0] TimerLast = 23'(REFRESH_DIV - 1);
    localparam logic [9:0]  ByteLast  = 10'(FRAME_LEN - 1);
    localparam logic [7:0]  LatLast   = 8'(ANN_LAT - 1);

    state_e      state;
    logic [22:0] timer;
    logic        refresh_pend;
    logic [9:0]  byte_cnt;
    logic [7:0]  lat_cnt;
    logic        src_log;
    logic        pend_take;

    assign pend_take = (state == StIdle) && enable && refresh_pend;

    // A tick coinciding with the frame start re-arms the pending flag.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            timer         <= '0;
            refresh_pend  <= 1'b0;
            frame_overrun <= 1'b0;
        end else if (!enable) begin
            timer        <= '0;
            refresh_pend <= 1'b0;
        end else if (timer == TimerLast) begin
            timer        <= '0;
            refresh_pend <= 1'b1;
            if (frame_active) begin
                frame_overrun <= 1'b1;
            end
        end else begin
            timer <= timer + 23'd1;
            if (pend_take) begin
                refresh_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            ann_inc      <= 1'b0;
            log_ready    <= 1'b0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            frame_active <= 1'b0;
            src_log      <= 1'b0;
            byte_cnt     <= '0;
            lat_cnt      <= '0;
        end else begin
            log_ready <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pend_take) begin
                        byte_cnt     <= '0;
                        lat_cnt      <= '0;
                        frame_active <= 1'b1;
                        ann_inc      <= 1'b1;
                        state        <= StAnnReq;
                    end else if (log_valid) begin
                        log_ready <= 1'b1;
                        tx_data   <= log_data;
                        tx_valid  <= 1'b1;
                        src_log   <= 1'b1;
                        state     <= StTxWait;
                    end
                end
                StAnnReq: begin
                    // Past the latency window, keep ann_inc high and re-sample every cycle.
                    if (lat_cnt >= LatLast && ann_dout_v) begin
                        tx_data  <= ann_dout;
                        tx_valid <= 1'b1;
                        ann_inc  <= 1'b0;
                        src_log  <= 1'b0;
                        state    <= StTxWait;
                    end else if (lat_cnt < LatLast) begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                StTxWait: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (src_log) begin
                            state <= StIdle;
                        end else if (byte_cnt == ByteLast) begin
                            frame_active <= 1'b0;
                            state        <= StIdle;
                        end else begin
                            byte_cnt <= byte_cnt + 10'd1;
                            state    <= StAnnGap;
                        end
                    end
                end
                StAnnGap: begin
                    lat_cnt <= '0;
                    ann_inc <= 1'b1;
                    state   <= StAnnReq;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_annunciator_sched.sv
// Directed-sequence bench for usb_annunciator_sched with randomized annunciator latency,
// log bytes and tx back-pressure; expected byte streams come from a frame/log model.
module tb_usb_annunciator_sched;

    localparam int unsigned FrameLen = 4;
    localparam int unsigned RefDiv   = 64;
    localparam int unsigned AnnLat   = 3;

    logic       clk48 = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       ann_inc;
    logic [7:0] ann_dout;
    logic       ann_dout_v;
    logic [7:0] log_data;
    logic       log_valid;
    logic       log_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       frame_active;
    logic       frame_overrun;

    usb_annunciator_sched #(
        .FRAME_LEN  (FrameLen),
        .REFRESH_DIV(RefDiv),
        .ANN_LAT    (AnnLat)
    ) dut (
        .clk48        (clk48),
        .rst_n        (rst_n),
        .enable       (enable),
        .ann_inc      (ann_inc),
        .ann_dout     (ann_dout),
        .ann_dout_v   (ann_dout_v),
        .log_data     (log_data),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .frame_active (frame_active),
        .frame_overrun(frame_overrun)
    );

    always #5 clk48 = ~clk48;

    int tests = 0;
    int fails = 0;

    // Annunciator model: byte n of the stream since reset is 8'h41+n, valid after 2..3 high edges.
    int hi_cnt;
    int pull_n;
    int dly;
    always @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt <= 0;
            pull_n <= 0;
            dly    <= 2;
        end else if (ann_inc) begin
            hi_cnt <= hi_cnt + 1;
        end else begin
            if (hi_cnt != 0) begin
                pull_n <= pull_n + 1;
                dly    <= int'($urandom_range(2, 3));
            end
            hi_cnt <= 0;
        end
    end
    assign ann_dout_v = (hi_cnt >= dly);
    assign ann_dout   = ann_dout_v ? 8'(8'h41 + pull_n) : 8'hEE;

    logic tx_hold = 1'b0;
    logic tx_rand = 1'b0;
    always @(posedge clk48) begin
        #2;
        tx_ready = tx_hold ? 1'b0 : (tx_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Monitor: collects handshaken bytes and tracks protocol properties.
    logic [7:0] lq[$];
    logic [7:0] got_b[$];
    logic       got_f[$];
    logic       log_en = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_ann = 1'b0;
    int         low_run = 99;
    int         ann_rises = 0;
    int         log_acc = 0;
    int         stab_err = 0;
    int         logfa_err = 0;
    int         gap_err = 0;
    always @(negedge clk48) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_ann   = 1'b0;
            low_run    = 99;
        end else begin
            if (tx_valid && tx_ready) begin
                got_b.push_back(tx_data);
                got_f.push_back(frame_active);
            end
            if (prev_stall && !(tx_valid && tx_data == prev_data)) stab_err++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (log_ready && frame_active) logfa_err++;
            if (log_ready) begin
                log_acc++;
                if (lq.size() != 0) void'(lq.pop_front());
            end
            if (ann_inc && !prev_ann) begin
                ann_rises++;
                if (low_run < 2) gap_err++;
            end
            low_run  = ann_inc ? 0 : low_run + 1;
            prev_ann = ann_inc;
        end
        log_valid = log_en && (lq.size() != 0);
        log_data  = (lq.size() != 0) ? lq[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input int f, input int off);
        logic [7:0] e;
        for (int k = 0; k < int'(FrameLen); k++) begin
            e = 8'(8'h41 + 4 * f + k);
            if (off + k < got_b.size()) begin
                check($sformatf("frame%0d_byte%0d", f, k), got_b[off+k], e);
                check($sformatf("frame%0d_active%0d", f, k), got_f[off+k], 1);
            end else begin
                check($sformatf("frame%0d_count", f), got_b.size(), off + int'(FrameLen));
            end
        end
    endtask

    task automatic wait_frame_start(input string tag);
        int n = 0;
        while (!frame_active && n < 300) begin
            @(posedge clk48);
            #1;
            n++;
        end
        check({tag, "_start"}, frame_active, 1);
    endtask

    task automatic wait_frame_end(input string tag);
        int n = 0;
        while (frame_active && n < 300) begin
            @(posedge clk48);
            #1;
            n++;
        end
        check({tag, "_end"}, frame_active, 0);
    endtask

    task automatic wait_first_rise(input string tag);
        int rise_at = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk48);
            #1;
            if (ann_inc) begin
                rise_at = i;
                break;
            end
        end
        check(tag, rise_at, 65);
        check({tag, "_active"}, frame_active, 1);
    endtask

    logic [7:0] exp_log[6];
    logic [7:0] held;
    logic       stable;
    int         n;

    initial begin
        rst_n  = 1'b1;
        enable = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk48);
        #1;
        check("rst_ann_inc", ann_inc, 0);
        check("rst_log_ready", log_ready, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_frame_active", frame_active, 0);
        check("rst_frame_overrun", frame_overrun, 0);

        // Periodic frame, tx always ready.
        ann_rises = 0;
        @(negedge clk48);
        rst_n = 1'b1;
        wait_first_rise("p1_first_rise");
        wait_frame_end("p1");
        check_frame(0, 0);
        check("p1_frame_len", got_b.size(), FrameLen);
        check("p1_ann_rises", ann_rises, FrameLen);

        // Log stream only, refresh disabled.
        @(negedge clk48);
        enable = 1'b0;
        tx_rand = 1'b1;
        got_b.delete();
        got_f.delete();
        ann_rises = 0;
        log_acc = 0;
        for (int i = 0; i < 6; i++) begin
            exp_log[i] = 8'($urandom);
            lq.push_back(exp_log[i]);
        end
        log_en = 1'b1;
        n = 0;
        while (!(got_b.size() == 6 && !tx_valid) && n < 400) begin
            @(posedge clk48);
            #1;
            n++;
        end
        check("p2_log_count", got_b.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_b.size()) begin
                check($sformatf("p2_log_byte%0d", i), got_b[i], exp_log[i]);
                check($sformatf("p2_log_active%0d", i), got_f[i], 0);
            end
        end
        check("p2_ann_rises", ann_rises, 0);
        check("p2_log_ready_pulses", log_acc, 6);

        // Refresh and log request arrive together: frame wins, log waits.
        got_b.delete();
        got_f.delete();
        @(negedge clk48);
        enable = 1'b1;
        repeat (64) @(posedge clk48);
        #1;
        lq.push_back(8'h55);
        @(posedge clk48);
        #1;
        check("p3_frame_first", frame_active, 1);
        check("p3_no_log_tx", tx_valid, 0);
        wait_frame_end("p3");
        n = 0;
        while (got_b.size() < 5 && n < 100) begin
            @(posedge clk48);
            #1;
            n++;
        end
        check_frame(1, 0);
        check("p3_total", got_b.size(), 5);
        if (got_b.size() >= 5) begin
            check("p3_log_after", got_b[4], 8'h55);
            check("p3_log_after_active", got_f[4], 0);
        end

        // tx stalled for 20 cycles on the first byte of a frame.
        tx_rand = 1'b0;
        got_b.delete();
        got_f.delete();
        wait_frame_start("p4");
        tx_hold = 1'b1;
        n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clk48);
            #1;
            n++;
        end
        held = tx_data;
        check("p4_held_byte", held, 8'h49);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk48);
            #1;
            if (!tx_valid || tx_data !== held || ann_inc) stable = 1'b0;
        end
        check("p4_stall_stable", stable, 1);
        tx_hold = 1'b0;
        wait_frame_end("p4");
        check_frame(2, 0);

        // Long stall makes a refresh tick land mid-frame.
        check("p5_overrun_before", frame_overrun, 0);
        got_b.delete();
        got_f.delete();
        wait_frame_start("p5");
        tx_hold = 1'b1;
        repeat (70) @(posedge clk48);
        #1;
        check("p5_overrun_set", frame_overrun, 1);
        tx_hold = 1'b0;
        wait_frame_end("p5a");
        @(posedge clk48);
        #1;
        check("p5_restart", frame_active, 1);
        wait_frame_end("p5b");
        check_frame(3, 0);
        check_frame(4, 4);
        check("p5_overrun_sticky", frame_overrun, 1);

        // Asynchronous reset while a pull is in progress.
        wait_frame_start("p6");
        #2;
        rst_n = 1'b0;
        #1;
        check("p6_async_ann_inc", ann_inc, 0);
        check("p6_async_tx_valid", tx_valid, 0);
        check("p6_async_frame_active", frame_active, 0);
        check("p6_async_overrun", frame_overrun, 0);
        @(negedge clk48);
        @(negedge clk48);
        got_b.delete();
        got_f.delete();
        rst_n = 1'b1;
        wait_first_rise("p6_first_rise");
        wait_frame_end("p6");
        check_frame(0, 0);

        check("mon_tx_stable", stab_err, 0);
        check("mon_log_in_frame", logfa_err, 0);
        check("mon_ann_gap", gap_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
